// File: rtl/cpu_host_ctrl_pkg.sv
// Shared encodings for the A-RISC host sequencer: command opcodes and FSM states.
package cpu_host_ctrl_pkg;

  localparam logic [1:0] OP_LOAD_I = 2'd0;
  localparam logic [1:0] OP_LOAD_D = 2'd1;
  localparam logic [1:0] OP_RUN    = 2'd2;
  localparam logic [1:0] OP_DUMP_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_I    = 3'd1,
    ST_LOAD_D    = 3'd2,
    ST_RUN_START = 3'd3,
    ST_RUN_WAIT  = 3'd4,
    ST_DUMP      = 3'd5
  } state_e;

endpackage

// File: rtl/cpu_host_ctrl_dram_port_mux.sv
// DRAM port owner select: controller request when it owns the port, core request otherwise.
module dram_port_mux #(
  parameter int W = 8
) (
  input  logic         own_i,
  input  logic [W-1:0] ctrl_addr_i,
  input  logic [W-1:0] ctrl_din_i,
  input  logic         ctrl_write_i,
  input  logic [W-1:0] cpu_addr_i,
  input  logic [W-1:0] cpu_din_i,
  input  logic         cpu_write_i,
  output logic [W-1:0] dram_addr_o,
  output logic [W-1:0] dram_din_o,
  output logic         dram_write_o
);

  assign dram_addr_o  = own_i ? ctrl_addr_i  : cpu_addr_i;
  assign dram_din_o   = own_i ? ctrl_din_i   : cpu_din_i;
  assign dram_write_o = own_i ? ctrl_write_i : cpu_write_i;

endmodule

// File: rtl/cpu_host_ctrl.sv
// Host-side sequencer: loads IRAM/DRAM, starts the core, waits for idle, dumps DRAM.
// Optional RUN watchdog enabled by defining CPU_TIMEOUT_EN.
module cpu_host_ctrl
  import cpu_host_ctrl_pkg::*;
#(
  parameter int W         = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_addr,
  input  logic [W-1:0] cmd_len,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [15:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic         iram_we,
  output logic [W-1:0] iram_waddr,
  output logic [15:0]  iram_wdata,
  input  logic [W-1:0] cpu_dram_addr,
  input  logic [W-1:0] cpu_dram_din,
  input  logic         cpu_dram_write,
  output logic [W-1:0] dram_addr,
  output logic [W-1:0] dram_din,
  output logic         dram_write,
  input  logic [W-1:0] dram_dout,
  output logic         cpu_start,
  input  logic         cpu_idle,
  output logic         cpu_rst,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_e               state_q, state_d;
  logic [W-1:0]         ptr_q, ptr_d;
  logic [W-1:0]         rem_q, rem_d;
  logic [W-1:0]         left_q, left_d;
  logic                 iss_done_q, iss_done_d;
  logic                 inflight_q, inflight_d;
  logic                 m_valid_q, m_valid_d;
  logic [W-1:0]         m_data_q, m_data_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cpu_rst_q, cpu_rst_d;
  logic                 beat_s;
  logic                 last_acc_s;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      left_q     <= '0;
      iss_done_q <= 1'b0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      left_q     <= left_d;
      iss_done_q <= iss_done_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  // Next-state, counter and readback logic
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    left_d     = left_q;
    iss_done_d = iss_done_q;
    inflight_d = 1'b0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    tmo_d      = tmo_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cpu_rst_d  = 1'b0;
    beat_s     = 1'b0;
    last_acc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ptr_d      = cmd_addr;
          rem_d      = cmd_len;
          left_d     = cmd_len;
          iss_done_d = 1'b0;
          tmo_d      = '0;
          err_d      = 1'b0;
          case (cmd_op)
            OP_LOAD_I: state_d = ST_LOAD_I;
            OP_LOAD_D: state_d = ST_LOAD_D;
            OP_RUN:    state_d = ST_RUN_START;
            OP_DUMP_D: state_d = ST_DUMP;
            default:   state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_I, ST_LOAD_D: begin
        if (s_valid) begin
          beat_s = 1'b1;
          ptr_d  = ptr_q + W'(1);
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - W'(1);
          end
        end else begin
          beat_s = 1'b0;
        end
      end
      ST_RUN_START: begin
        tmo_d   = '0;
        state_d = ST_RUN_WAIT;
      end
      ST_RUN_WAIT: begin
        // tmo_q == 0 marks the first wait cycle, where the core's idle flag is still stale
        if ((tmo_q != '0) && cpu_idle) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
`ifdef CPU_TIMEOUT_EN
          if (tmo_q == '1) begin
            cpu_rst_d = 1'b1;
            err_d     = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TIMEOUT_W'(1);
          end
`else
          if (tmo_q != '1) begin
            tmo_d = tmo_q + TIMEOUT_W'(1);
          end else begin
            tmo_d = tmo_q;
          end
`endif
        end
      end
      ST_DUMP: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          if (left_q == '0) begin
            last_acc_s = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            left_d = left_q - W'(1);
          end
        end else begin
          m_valid_d = m_valid_q;
        end
        if (inflight_q) begin
          m_data_d  = dram_dout;
          m_valid_d = 1'b1;
        end else begin
          m_data_d = m_data_q;
        end
        // Issue only when the output register is guaranteed free by the time data returns
        if (!inflight_q && !iss_done_q && (!m_valid_q || m_ready)) begin
          inflight_d = 1'b1;
          ptr_d      = ptr_q + W'(1);
          if (rem_q == '0) begin
            iss_done_d = 1'b1;
          end else begin
            rem_d = rem_q - W'(1);
          end
        end else begin
          inflight_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == ST_IDLE) && !rst;
  assign s_ready    = (state_q == ST_LOAD_I) || (state_q == ST_LOAD_D);
  assign busy       = (state_q != ST_IDLE);
  assign cpu_start  = (state_q == ST_RUN_START);
  assign done       = done_q | last_acc_s;
  assign err        = err_q;
  assign cpu_rst    = cpu_rst_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign iram_we    = beat_s && (state_q == ST_LOAD_I);
  assign iram_waddr = ptr_q;
  assign iram_wdata = s_data;

  dram_port_mux #(.W(W)) u_dram_mux (
    .own_i        ((state_q == ST_LOAD_D) || (state_q == ST_DUMP)),
    .ctrl_addr_i  (ptr_q),
    .ctrl_din_i   (s_data[W-1:0]),
    .ctrl_write_i (beat_s && (state_q == ST_LOAD_D)),
    .cpu_addr_i   (cpu_dram_addr),
    .cpu_din_i    (cpu_dram_din),
    .cpu_write_i  (cpu_dram_write),
    .dram_addr_o  (dram_addr),
    .dram_din_o   (dram_din),
    .dram_write_o (dram_write)
  );

endmodule
